// File: rtl/rate_timer_pkg.sv
// Shared defaults for the rate timer: counter width, the four selectable periods
// and the rate-select encoding. The top level and the bench override them here.
package rate_timer_pkg;

    localparam int          NB_COUNTER_DEF = 32;
    localparam int unsigned R0_DEF         = 2 ** 23;
    localparam int unsigned R1_DEF         = 2 ** 24;
    localparam int unsigned R2_DEF         = 2 ** 25;
    localparam int unsigned R3_DEF         = 2 ** 26;

    typedef enum logic [1:0] {
        SEL_R0 = 2'd0,
        SEL_R1 = 2'd1,
        SEL_R2 = 2'd2,
        SEL_R3 = 2'd3
    } rate_sel_e;

endpackage

// File: rtl/rate_timer.sv
// Programmable-period strobe generator: a counter runs against one of four
// switch-selected periods and emits a registered one-cycle o_valid per period.
module rate_timer
    import rate_timer_pkg::*;
#(
    parameter int                    NB_COUNTER = NB_COUNTER_DEF,
    parameter logic [NB_COUNTER-1:0] R0         = NB_COUNTER'(R0_DEF),
    parameter logic [NB_COUNTER-1:0] R1         = NB_COUNTER'(R1_DEF),
    parameter logic [NB_COUNTER-1:0] R2         = NB_COUNTER'(R2_DEF),
    parameter logic [NB_COUNTER-1:0] R3         = NB_COUNTER'(R3_DEF)
) (
    input  logic       clock,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic [1:0] i_sel,
    output logic       o_valid
);

    localparam logic [NB_COUNTER-1:0] ONE = NB_COUNTER'(1);

    // Terminal count is period-1: the strobe lands on the period-th counting edge.
    localparam logic [NB_COUNTER-1:0] T0 = R0 - ONE;
    localparam logic [NB_COUNTER-1:0] T1 = R1 - ONE;
    localparam logic [NB_COUNTER-1:0] T2 = R2 - ONE;
    localparam logic [NB_COUNTER-1:0] T3 = R3 - ONE;

    logic [NB_COUNTER-1:0] r_cnt;
    rate_sel_e             r_sel_q;
    logic                  r_valid_q;
    logic [NB_COUNTER-1:0] w_terminal;

    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        w_terminal = T0;
        case (r_sel_q)
            SEL_R0:  w_terminal = T0;
            SEL_R1:  w_terminal = T1;
            SEL_R2:  w_terminal = T2;
            SEL_R3:  w_terminal = T3;
            default: w_terminal = T0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_sel_q   <= SEL_R0;
            r_valid_q <= 1'b0;
        end else if (i_sel != r_sel_q) begin
            // A rate change restarts the period and swallows any strobe due on this edge.
            r_sel_q   <= rate_sel_e'(i_sel);
            r_cnt     <= '0;
            r_valid_q <= 1'b0;
        end else if (!i_enable) begin
            r_valid_q <= 1'b0;
        end else if (r_cnt >= w_terminal) begin
            // >= rather than == so an out-of-range count still recovers.
            r_cnt     <= '0;
            r_valid_q <= 1'b1;
        end else begin
            r_cnt     <= r_cnt + ONE;
            r_valid_q <= 1'b0;
        end
    end

    assign o_valid = r_valid_q;

endmodule

// File: tb/tb_rate_timer.sv
// Directed and randomized checks of rate_timer against a model that counts
// enabled edges since the last period restart.
module tb_rate_timer;

    localparam logic [31:0] TB_R0 = 32'd4;
    localparam logic [31:0] TB_R1 = 32'd3;
    localparam logic [31:0] TB_R2 = 32'd7;
    localparam logic [31:0] TB_R3 = 32'd1;

    logic       clock = 1'b0;
    logic       i_reset;
    logic       i_enable;
    logic [1:0] i_sel;
    logic       o_valid;

    int checks = 0;
    int errors = 0;

    // Model state: enabled edges since the period last restarted.
    int         m_progress = 0;
    logic [1:0] m_sel      = 2'd0;
    logic       m_valid    = 1'b0;

    rate_timer #(
        .NB_COUNTER (32),
        .R0         (TB_R0),
        .R1         (TB_R1),
        .R2         (TB_R2),
        .R3         (TB_R3)
    ) dut (
        .clock    (clock),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_sel    (i_sel),
        .o_valid  (o_valid)
    );

    always #5 clock = ~clock;

    function automatic int period_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return int'(TB_R0);
            2'd1:    return int'(TB_R1);
            2'd2:    return int'(TB_R2);
            default: return int'(TB_R3);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, expv, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic [1:0] sel);
        if (rst) begin
            m_progress = 0;
            m_sel      = 2'd0;
            m_valid    = 1'b0;
        end else if (sel != m_sel) begin
            m_sel      = sel;
            m_progress = 0;
            m_valid    = 1'b0;
        end else if (!en) begin
            m_valid    = 1'b0;
        end else begin
            m_progress = m_progress + 1;
            m_valid    = (m_progress >= period_of(m_sel));
            if (m_valid) m_progress = 0;
        end
    endtask

    task automatic step(input logic rst, input logic en, input logic [1:0] sel);
        i_reset  = rst;
        i_enable = en;
        i_sel    = sel;
        @(posedge clock);
        model_edge(rst, en, sel);
        #1;
        check("o_valid_vs_model", {31'd0, o_valid}, {31'd0, m_valid});
    endtask

    task automatic run(input int n, input logic rst, input logic en, input logic [1:0] sel,
                       output int pulses, output int first);
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= n; k++) begin
            step(rst, en, sel);
            if (o_valid === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
    endtask

    initial begin
        int p;
        int f;
        logic       r_rst;
        logic       r_en;
        logic [1:0] r_sel;

        i_reset  = 1'b1;
        i_enable = 1'b0;
        i_sel    = 2'd0;

        // Reset state
        run(2, 1'b1, 1'b1, 2'd0, p, f);
        check("reset_no_pulse", p, 0);

        // Reset release then enable: period 4, first pulse on the 4th edge
        run(20, 1'b0, 1'b1, 2'd0, p, f);
        check("r0_pulse_count", p, 5);
        check("r0_first_pulse", f, 4);

        // Rate select 2 (period 7), ending mid-count
        run(25, 1'b0, 1'b1, 2'd2, p, f);
        check("r2_pulse_count", p, 3);
        check("r2_first_pulse", f, 8);

        // Switch to select 1 (period 3) mid-count
        run(1, 1'b0, 1'b1, 2'd1, p, f);
        check("sel_change_no_pulse", p, 0);
        run(6, 1'b0, 1'b1, 2'd1, p, f);
        check("r1_first_pulse", f, 3);
        check("r1_pulse_count", p, 2);

        // Freeze mid-count: 2 counted edges, 10 frozen, then 2 more to the strobe
        run(3, 1'b0, 1'b1, 2'd0, p, f);
        check("freeze_pre_count", p, 0);
        run(10, 1'b0, 1'b0, 2'd0, p, f);
        check("freeze_no_pulse", p, 0);
        run(4, 1'b0, 1'b1, 2'd0, p, f);
        check("freeze_resume_first", f, 2);
        check("freeze_resume_count", p, 1);

        // Freeze exactly on the terminal edge: strobe waits for re-enable
        run(1, 1'b0, 1'b1, 2'd0, p, f);
        check("terminal_pre", p, 0);
        run(4, 1'b0, 1'b0, 2'd0, p, f);
        check("terminal_frozen", p, 0);
        run(1, 1'b0, 1'b1, 2'd0, p, f);
        check("terminal_release", f, 1);

        // Period 1: high every enabled edge after the select-change edge
        run(6, 1'b0, 1'b1, 2'd3, p, f);
        check("r3_pulse_count", p, 5);
        check("r3_first_pulse", f, 2);
        run(3, 1'b0, 1'b0, 2'd3, p, f);
        check("r3_disabled", p, 0);
        run(2, 1'b0, 1'b1, 2'd3, p, f);
        check("r3_reenabled", p, 2);

        // Mid-period reset discards the count
        run(3, 1'b0, 1'b1, 2'd0, p, f);
        check("pre_reset_count", p, 0);
        run(1, 1'b1, 1'b1, 2'd0, p, f);
        check("mid_reset_no_pulse", p, 0);
        run(8, 1'b0, 1'b1, 2'd0, p, f);
        check("post_reset_first", f, 4);
        check("post_reset_count", p, 2);

        // Randomized traffic against the model
        r_sel = 2'd0;
        for (int k = 0; k < 600; k++) begin
            r_rst = ($urandom_range(0, 99) == 0);
            r_en  = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) r_sel = 2'($urandom_range(0, 3));
            step(r_rst, r_en, r_sel);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rate_timer.md
Name: rate_timer

Overview:
- Programmable-period pulse generator that drives the `i_valid` input of the LED flash/shift stage directly downstream.
- A free-running counter runs against one of four switch-selected limits. Each time the limit is reached, the block emits a one-cycle `o_valid` strobe.
- Switches select the rate and enable or freeze counting. Reset is shared with the downstream stage.

Parameters:
- NB_COUNTER, 32, counter width in bits.
- R0, 2**23, period in clock cycles for select 0; must be >= 1 and < 2**NB_COUNTER.
- R1, 2**24, period for select 1; same constraints.
- R2, 2**25, period for select 2; same constraints.
- R3, 2**26, period for select 3; same constraints.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_enable  input  1  1 = count; 0 = freeze counter, no strobes.
- i_sel  input  2  rate select, chooses R0..R3.
- o_valid  output  1  registered one-cycle strobe, high once per selected period.

Behaviour:
- One clock; reset is synchronous and active-high, port names `clock` and `i_reset`.
- State:
  - `cnt` [NB_COUNTER-1:0]
  - `sel_q` [1:0], the registered select
  - `valid_q`, which drives `o_valid` directly (no combinational path from inputs).
- Reset (`i_reset`=1 at an edge):
  - `cnt`<=0, `sel_q`<=0, `valid_q`<=0.
  - `o_valid` is 0 in the cycle following the reset edge.
- Per-edge priority when not in reset. Exactly one branch applies:
  1. Select change (`i_sel` != `sel_q`): `sel_q`<=`i_sel`, `cnt`<=0, `valid_q`<=0. This overrides `i_enable`.
  2. `i_enable`=0: `cnt` holds, `valid_q`<=0.
  3. `cnt` >= limit(`sel_q`)-1: `cnt`<=0, `valid_q`<=1.
  4. Otherwise: `cnt`<=`cnt`+1, `valid_q`<=0.
- `limit(sel_q)` is a constant mux of R0..R3. The comparison is unsigned at NB_COUNTER width.
  - Using >= (rather than ==) guarantees recovery if `cnt` exceeds the limit.
- Period and latency:
  - With enable held high and select stable, `o_valid` is high for exactly 1 cycle in every limit cycles.
  - The first strobe occurs on the limit-th rising edge after the first counting edge.
  - Limit 1 gives `o_valid` high every cycle while enabled.
- Enable deasserted mid-count: count is preserved. On re-enable, counting resumes from the held value, so total enabled cycles between strobes is still the limit.
- Enable deasserted on the edge where a strobe would have fired: no strobe, `cnt` held at limit-1. The strobe fires on the first enabled edge.
- Select change: restarts the period from 0 and suppresses any strobe on that edge. No strobe arrives early or late relative to the new rate.
- Reset asserted mid-period: discards the count. Reset wins over all branches.
- Counter never wraps through 2**NB_COUNTER, because limits are constrained below that.

Decomposition:
- Parameter defaults R0..R3 and NB_COUNTER go in the shared tp-level parameter/include file, so the top level and the bench override them in one place.
- No sub-module: the limit mux and counter stay in one module.
- The top level connects `o_valid` to `flash.i_valid` and shares `clock`/`i_reset`.

Test Plan:
- Reset then enable: R0=4, `i_sel`=0, `i_enable`=1, release reset → `o_valid` pulses high 1 cycle on the 4th edge after release, then every 4 cycles; 5 pulses in 20 cycles.
- Rate select: R2=7, `i_sel`=2 held → pulse spacing exactly 7 cycles. Switch to `i_sel`=1 (R1=3) mid-count → no pulse on the switch edge; next pulse 3 enabled edges later, then spacing 3.
- Freeze: R0=5, drop `i_enable` after 2 counted edges for 10 cycles → `o_valid`=0 throughout; pulse occurs after 3 more enabled edges.
- Freeze at terminal: `i_enable`=0 exactly on the edge `cnt`=4 with R0=5 → no pulse; pulse on the first edge after re-enable.
- Limit 1: R3=1, `i_sel`=3 → `o_valid` constantly 1 while enabled (after the select-change cycle), 0 when disabled.
- Mid-period reset: R0=8, assert `i_reset` at `cnt`=6 for 1 cycle → `o_valid`=0; next pulse 8 edges after release. Paired with flash, LEDs toggle 0→~0 exactly per pulse.
